// File: rtl/adc_joystick_ctrl.sv
// rtl/adc_joystick_ctrl.sv - joystick front end: ADC channel sequencing, averaging, direction pulses with auto-repeat
module adc_joystick_ctrl #(
  parameter int          FRAME_CYCLES   = 16,
  parameter int          DISCARD_FRAMES = 2,
  parameter int          AVG_LOG2       = 2,
  parameter logic [2:0]  X_CHAN         = 3'd0,
  parameter logic [2:0]  Y_CHAN         = 3'd1,
  parameter logic [11:0] LOW_TH         = 12'd1024,
  parameter logic [11:0] HIGH_TH        = 12'd3072,
  parameter logic [11:0] HYST           = 12'd128,
  parameter logic [23:0] REPEAT_DELAY   = 24'd6_000_000,
  parameter logic [23:0] REPEAT_PERIOD  = 24'd2_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] adc_result,
  output logic [2:0]  adc_chan,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        sample_valid,
  output logic        move_left,
  output logic        move_right,
  output logic        move_down,
  output logic        rotate
);

  localparam int FCW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int AW  = 12 + AVG_LOG2;
  localparam int SW  = AVG_LOG2 + 1;
  localparam logic [FCW-1:0] FC_LAST   = FCW'(FRAME_CYCLES - 1);
  localparam logic [7:0]     DISC_LAST = 8'(DISCARD_FRAMES - 1);
  localparam logic [SW-1:0]  SAMP_LAST = SW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {SETTLE, ACCUM, UPDATE} state_t;
  typedef enum logic [1:0] {CENTER, NEG, POS} dir_t;

  state_t         state;
  logic [FCW-1:0] fcnt;
  logic [7:0]     disc_cnt;
  logic [SW-1:0]  samp_cnt;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  acc_sum;
  logic           axis;
  logic [2:0]     next_chan;
  logic           frame_end;

  assign frame_end = (fcnt == FC_LAST);
  assign acc_sum   = acc + AW'(adc_result);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SETTLE;
      fcnt         <= '0;
      disc_cnt     <= '0;
      samp_cnt     <= '0;
      acc          <= '0;
      axis         <= 1'b0;
      next_chan    <= X_CHAN;
      adc_chan     <= X_CHAN;
      x_pos        <= 12'd2048;
      y_pos        <= 12'd2048;
      sample_valid <= 1'b0;
    end else begin
      fcnt         <= frame_end ? '0 : fcnt + 1'b1;
      sample_valid <= 1'b0;
      // The ADC interface only sees a channel change at its own frame boundary.
      if (frame_end)
        adc_chan <= next_chan;
      case (state)
        SETTLE: begin
          if (frame_end) begin
            if (disc_cnt == DISC_LAST) begin
              disc_cnt <= '0;
              state    <= ACCUM;
            end else begin
              disc_cnt <= disc_cnt + 8'd1;
            end
          end
        end
        ACCUM: begin
          if (frame_end) begin
            acc <= acc_sum;
            if (samp_cnt == SAMP_LAST) begin
              samp_cnt     <= '0;
              sample_valid <= 1'b1;
              state        <= UPDATE;
              if (axis)
                y_pos <= acc_sum[AW-1:AVG_LOG2];
              else
                x_pos <= acc_sum[AW-1:AVG_LOG2];
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end
        end
        UPDATE: begin
          acc       <= '0;
          axis      <= ~axis;
          next_chan <= axis ? X_CHAN : Y_CHAN;
          state     <= SETTLE;
        end
        default: state <= SETTLE;
      endcase
    end
  end

  function automatic dir_t next_dir(input dir_t d, input logic [11:0] v);
    dir_t n;
    n = d;
    case (d)
      CENTER: begin
        if (v < LOW_TH)       n = NEG;
        else if (v > HIGH_TH) n = POS;
      end
      NEG: begin
        if (v > HIGH_TH)              n = POS;
        else if (v >= LOW_TH + HYST)  n = CENTER;
      end
      POS: begin
        if (v < LOW_TH)               n = NEG;
        else if (v <= HIGH_TH - HYST) n = CENTER;
      end
      default: n = CENTER;
    endcase
    return n;
  endfunction

  dir_t        dir      [2];
  dir_t        nd       [2];
  logic [23:0] rcnt     [2];
  logic        rfirst   [2];
  logic        chg      [2];
  logic        rep_hit  [2];
  logic        fire_neg [2];
  logic        fire_pos [2];
  logic [11:0] cur_avg;

  // Index 0 is the X axis, index 1 the Y axis; Y POS (rotate) never repeats.
  always_comb begin
    cur_avg = axis ? y_pos : x_pos;
    for (int a = 0; a < 2; a++) begin
      nd[a] = dir[a];
      if (state == UPDATE && axis == (a == 1))
        nd[a] = next_dir(dir[a], cur_avg);
      chg[a]      = (nd[a] != dir[a]);
      rep_hit[a]  = (dir[a] == NEG || (dir[a] == POS && a == 0)) &&
                    (rcnt[a] == (rfirst[a] ? REPEAT_DELAY - 24'd1 : REPEAT_PERIOD - 24'd1));
      fire_neg[a] = chg[a] ? (nd[a] == NEG) : (dir[a] == NEG && rep_hit[a]);
      fire_pos[a] = chg[a] ? (nd[a] == POS) : (dir[a] == POS && rep_hit[a]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_left  <= 1'b0;
      move_right <= 1'b0;
      move_down  <= 1'b0;
      rotate     <= 1'b0;
      for (int a = 0; a < 2; a++) begin
        dir[a]    <= CENTER;
        rcnt[a]   <= '0;
        rfirst[a] <= 1'b1;
      end
    end else begin
      move_left  <= fire_neg[0];
      move_right <= fire_pos[0];
      move_down  <= fire_neg[1];
      rotate     <= fire_pos[1];
      for (int a = 0; a < 2; a++) begin
        if (chg[a]) begin
          dir[a]    <= nd[a];
          rcnt[a]   <= '0;
          rfirst[a] <= 1'b1;
        end else if (rep_hit[a]) begin
          rcnt[a]   <= '0;
          rfirst[a] <= 1'b0;
        end else if (dir[a] != CENTER) begin
          rcnt[a]   <= rcnt[a] + 24'd1;
        end else begin
          rcnt[a]   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_joystick_ctrl.sv
// tb/tb_adc_joystick_ctrl.sv - self-checking bench for adc_joystick_ctrl
module tb_adc_joystick_ctrl;

  localparam int RD = 300;
  localparam int RP = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] adc_result;
  logic [2:0]  adc_chan;
  logic [11:0] x_pos, y_pos;
  logic        sample_valid, move_left, move_right, move_down, rotate;

  adc_joystick_ctrl #(
    .REPEAT_DELAY (24'(RD)),
    .REPEAT_PERIOD(24'(RP))
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .adc_result  (adc_result),
    .adc_chan    (adc_chan),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .sample_valid(sample_valid),
    .move_left   (move_left),
    .move_right  (move_right),
    .move_down   (move_down),
    .rotate      (rotate)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: cycle 0 is the first clock edge after reset release,
  // each axis update spans 6 frames of 16 cycles, frames 2..5 are averaged.
  int          gcyc;
  int          upd;
  int          dirm     [2];   // 0 center, 1 neg, 2 pos
  int          entry_at [2];
  int          next_rep [2];
  logic [11:0] exp_x, exp_y;
  logic [11:0] fv [6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, expv, gcyc);
    end
  endtask

  function automatic int model_dir(input int d, input int v);
    case (d)
      0:       return (v < 1024) ? 1 : (v > 3072) ? 2 : 0;
      1:       return (v > 3072) ? 2 : (v >= 1024 + 128) ? 0 : 1;
      default: return (v < 1024) ? 1 : (v <= 3072 - 128) ? 0 : 2;
    endcase
  endfunction

  function automatic logic [3:0] pulse_bits(input int a, input int d);
    if (a == 0) return (d == 1) ? 4'b1000 : 4'b0100;
    return (d == 1) ? 4'b0010 : 4'b0001;
  endfunction

  task automatic model_reset();
    gcyc  = 0;
    upd   = 0;
    exp_x = 12'd2048;
    exp_y = 12'd2048;
    for (int a = 0; a < 2; a++) begin
      dirm[a]     = 0;
      entry_at[a] = -1;
      next_rep[a] = -1;
    end
  endtask

  task automatic check_reset_values();
    check("rst_x_pos", x_pos, 12'd2048);
    check("rst_y_pos", y_pos, 12'd2048);
    check("rst_adc_chan", adc_chan, 3'd0);
    check("rst_sample_valid", sample_valid, 1'b0);
    check("rst_pulses", {move_left, move_right, move_down, rotate}, 4'b0000);
  endtask

  task automatic tick(input int k);
    logic [3:0] ep;
    int         avg, ax, nd, chan_exp;
    adc_result = fv[k / 16];
    @(posedge clk);
    @(negedge clk);
    ep = 4'b0000;
    for (int a = 0; a < 2; a++) begin
      if (entry_at[a] == gcyc) begin
        ep |= pulse_bits(a, dirm[a]);
      end else if (dirm[a] != 0 && !(a == 1 && dirm[a] == 2) && next_rep[a] == gcyc) begin
        ep |= pulse_bits(a, dirm[a]);
        next_rep[a] += RP;
      end
    end
    check("sample_valid", sample_valid, (k == 95));
    if (k == 95) begin
      avg = (int'(fv[2]) + int'(fv[3]) + int'(fv[4]) + int'(fv[5])) / 4;
      ax  = upd % 2;
      if (ax == 0) exp_x = 12'(avg);
      else         exp_y = 12'(avg);
      nd = model_dir(dirm[ax], avg);
      if (nd != dirm[ax]) begin
        dirm[ax] = nd;
        entry_at[ax] = (nd != 0) ? gcyc + 1 : -1;
        next_rep[ax] = (nd != 0) ? gcyc + 1 + RD : -1;
      end
    end
    chan_exp = (k >= 15) ? upd % 2 : ((upd == 0) ? 0 : (upd - 1) % 2);
    check("x_pos", x_pos, exp_x);
    check("y_pos", y_pos, exp_y);
    check("pulses", {move_left, move_right, move_down, rotate}, ep);
    check("adc_chan", adc_chan, chan_exp);
    check("left_right_excl", move_left & move_right, 1'b0);
    gcyc++;
  endtask

  task automatic run_update(input int ncyc);
    for (int k = 0; k < ncyc; k++) tick(k);
    if (ncyc == 96) upd++;
  endtask

  task automatic set_const(input int v);
    for (int f = 0; f < 6; f++) fv[f] = 12'(v);
  endtask

  task automatic set_rand(input int lo, input int hi);
    for (int f = 0; f < 6; f++) fv[f] = 12'(lo + int'($urandom_range(0, hi - lo)));
  endtask

  task automatic xy(input int xv, input int yv);
    set_const(xv); run_update(96);
    set_const(yv); run_update(96);
  endtask

  initial begin
    int r;
    reset      = 1'b1;
    adc_result = 12'd0;
    model_reset();
    set_const(0);
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b0;

    // Constant mid-scale input: both axes settle at 2000, no commands.
    xy(2000, 2000);

    // Averaging of distinct samples, entering NEG on X.
    fv[0] = 12'd2000; fv[1] = 12'd2000;
    fv[2] = 12'd100;  fv[3] = 12'd200; fv[4] = 12'd300; fv[5] = 12'd400;
    run_update(96);
    set_const(2000); run_update(96);

    // X held low: entry plus auto-repeat, then hysteresis hold and release.
    xy(500, 2000);
    xy(500, 2000);
    xy(1100, 2000);
    xy(1200, 2000);

    // Y held high: single rotate, then again after a return to center.
    for (int i = 0; i < 5; i++) xy(2000, 4000);
    xy(2000, 2048);
    xy(2000, 4000);

    // Direct NEG to POS swing on X.
    xy(100, 2000);
    xy(4000, 2000);

    // Randomized per-frame values across all threshold regions.
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 4);
      case (r)
        0:       set_rand(0, 900);
        1:       set_rand(1000, 1300);
        2:       set_rand(1800, 2300);
        3:       set_rand(2900, 3300);
        default: set_rand(3500, 4095);
      endcase
      run_update(96);
    end

    // Reset in the middle of X accumulation while X is POS.
    xy(3500, 2000);
    set_const(3500);
    run_update(70);
    reset = 1'b1;
    #1;
    check_reset_values();
    repeat (3) @(negedge clk);
    check_reset_values();
    model_reset();
    reset = 1'b0;
    xy(3500, 2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_joystick_ctrl.md
ADC_JOYSTICK_CTRL -- requirements
Module: adc_joystick_ctrl

Interface
REQ-001 Parameter FRAME_CYCLES, default 16: clk cycles per ADC conversion frame.
REQ-002 Parameter DISCARD_FRAMES, default 2: frames ignored after each channel change.
REQ-003 Parameter AVG_LOG2, default 2: log2 of samples averaged per axis update.
REQ-004 Parameters X_CHAN = 3'd0 and Y_CHAN = 3'd1: ADC channels for the X and Y axes.
REQ-005 Parameters LOW_TH = 12'd1024, HIGH_TH = 12'd3072, HYST = 12'd128: direction thresholds.
REQ-006 Parameters REPEAT_DELAY = 24'd6_000_000 and REPEAT_PERIOD = 24'd2_500_000: auto-repeat timing in clk cycles.
REQ-007 Port clk, input, 1: single clock, shared with the ADC interface.
REQ-008 Port reset, input, 1: asynchronous, active-high reset.
REQ-009 Port adc_result, input, 12: conversion result from the ADC interface; it updates once per frame.
REQ-010 Port adc_chan, output, 3: channel select to the ADC interface.
REQ-011 Port x_pos and y_pos, output, 12 each: registered averaged axis values.
REQ-012 Port sample_valid, output, 1: one-cycle pulse when x_pos or y_pos updates.
REQ-013 Port move_left, move_right, move_down, rotate, output, 1 each: one-cycle command pulses.

Function
REQ-014 A free-running frame counter SHALL count 0..FRAME_CYCLES-1 and wrap; it starts at 0 out of reset, aligned with the ADC interface frame counter.
REQ-015 adc_chan SHALL change only on the cycle where the frame counter wraps to 0.
REQ-016 The FSM SHALL have the states SETTLE, ACCUM and UPDATE; it leaves reset in SETTLE with adc_chan = X_CHAN.
REQ-017 SETTLE: the FSM SHALL count DISCARD_FRAMES frame ends (frame counter == FRAME_CYCLES-1) and then enter ACCUM.
REQ-018 ACCUM: at each frame end the block SHALL add adc_result into a (12+AVG_LOG2)-bit accumulator; after 2^AVG_LOG2 samples it SHALL enter UPDATE.
REQ-019 UPDATE, one cycle: the block SHALL write accumulator >> AVG_LOG2 (truncating) to the current axis output and pulse sample_valid.
REQ-019a In the same UPDATE cycle it SHALL clear the accumulator, toggle the axis, schedule adc_chan for the next frame boundary, and return to SETTLE.
REQ-020 Axis update period SHALL be (DISCARD_FRAMES + 2^AVG_LOG2) frames; with defaults, 96 cycles.
REQ-021 Per-axis direction state SHALL be one of CENTER, NEG or POS, evaluated only in UPDATE for the axis just written.
REQ-022 Transition CENTER->NEG SHALL occur when avg < LOW_TH; CENTER->POS SHALL occur when avg > HIGH_TH.
REQ-023 Transition NEG->CENTER SHALL occur when avg >= LOW_TH+HYST; POS->CENTER SHALL occur when avg <= HIGH_TH-HYST.
REQ-024 NEG<->POS SHALL move directly when the opposite threshold is crossed, and SHALL count as a new entry.
REQ-025 Pulse mapping: X NEG = move_left, X POS = move_right, Y NEG = move_down, Y POS = rotate.
REQ-026 Entering NEG or POS SHALL pulse the mapped output for one cycle, in the cycle after UPDATE.
REQ-027 Auto-repeat for move_left, move_right and move_down, while the state is held:
- first repeat pulse REPEAT_DELAY cycles after the entry pulse;
- then one pulse every REPEAT_PERIOD cycles.
REQ-027a The repeat timer SHALL restart on any state change.
REQ-028 rotate SHALL never auto-repeat; it requires a return to CENTER before it can pulse again.
REQ-029 At most one of move_left and move_right SHALL be high in any cycle; X and Y pulses in the same cycle are permitted.
REQ-030 Entering CENTER SHALL produce no pulse and SHALL clear that axis repeat timer.

Reset
REQ-031 Reset SHALL force the following values:
- frame counter = 0, state = SETTLE, adc_chan = X_CHAN;
- accumulator = 0; x_pos = y_pos = 12'd2048;
- both axes = CENTER; all pulse outputs and sample_valid = 0; repeat timers = 0.
REQ-032 Reset asserted mid-ACCUM SHALL discard the partial accumulation; no sample_valid SHALL follow reset release until a full SETTLE+ACCUM sequence completes.

Verification
REQ-033 Constant adc_result = 12'd2000 -> first sample_valid at cycle 95 after reset release with x_pos = 2000; y_pos = 2000 at cycle 191; no command pulses.
REQ-034 Four X samples 100, 200, 300, 400 -> x_pos = 250, state NEG, one move_left pulse in the cycle after UPDATE.
REQ-035 X held at 500 with REPEAT_DELAY = 300 and REPEAT_PERIOD = 100 -> move_left pulses at entry, +300, +400, +500, ...
REQ-035a In the same setup, X raised to 1100 -> stays NEG (hysteresis); X raised to 1200 -> CENTER and pulses stop.
REQ-036 Y held at 4000 for 5 updates -> exactly one rotate pulse; Y to 2048 then back to 4000 -> a second rotate pulse.
REQ-037 Averages X = 100, then X = 4000 on the next X update -> one move_left then one move_right, never both asserted together.
REQ-038 Reset asserted at frame 3 of ACCUM on X -> all outputs return to reset values; the next x_pos update occurs 96 cycles after release.
